ifetch_unit: RTL and testbench

Instruction fetch unit that consumes the 32-bit program counter and reads the addressed word from instruction memory over a req/ack handshake. It delivers one instruction per fetch into an IF/ID output register with valid, stall and flush control. It drives PcHold back to the PC block so the PC advances only when a fetch completes.

---
 rtl/ifetch_unit_if.sv | 33 +++
 rtl/ifetch_unit.sv | 147 ++++++++++++++
 tb/tb_ifetch_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: PC/pipeline control, instruction-memory handshake,
// and the IF/ID output register. The fetch unit is the memory-bus master.
interface ifetch_unit_if #(
    parameter int ADDR_W = 10
);
    logic [31:0]       PC;
    logic              Stall;
    logic              Flush;
    logic              ImemReq;
    logic [ADDR_W-1:0] ImemAddr;
    logic              ImemAck;
    logic [31:0]       ImemData;
    logic [31:0]       Instr;
    logic [31:0]       InstrPC;
    logic              InstrValid;
    logic              FetchFault;
    logic [1:0]        FaultCode;
    logic              PcHold;

    // Fetch unit side
    modport master (
        input  PC, Stall, Flush, ImemAck, ImemData,
        output ImemReq, ImemAddr, Instr, InstrPC, InstrValid,
               FetchFault, FaultCode, PcHold
    );

    // Environment side: PC block, instruction memory, decode stage
    modport slave (
        output PC, Stall, Flush, ImemAck, ImemData,
        input  ImemReq, ImemAddr, Instr, InstrPC, InstrValid,
               FetchFault, FaultCode, PcHold
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request per PC,
// supports zero-wait and multi-cycle acks, substitutes a nop on misaligned,
// out-of-range or timed-out fetches, and holds the PC until a fetch resolves.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter int          ADDR_W    = 10,
    parameter int          TIMEOUT   = 15
) (
    input  logic          Clk,
    input  logic          Reset,
    ifetch_unit_if.master bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0]  FC_NONE  = 2'b00;
    localparam logic [1:0]  FC_MISAL = 2'b01;
    localparam logic [1:0]  FC_RANGE = 2'b10;
    localparam logic [1:0]  FC_TMO   = 2'b11;
    // One past the last valid byte address, kept in 33 bits so it cannot wrap.
    localparam logic [32:0] LIMIT    = {1'b0, IMEM_BASE} + (33'd4 << ADDR_W);
    // The counter value at which the next unacknowledged WAIT edge times out.
    localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [31:0] req_pc_q;
    logic [7:0]  cnt_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        valid_q;
    logic        fault_q;
    logic [1:0]  code_q;

    logic        blocked_s;
    logic        aligned_s;
    logic        inrange_s;
    logic        req_s;
    logic        ack_s;
    logic        timeout_hit_s;
    logic [31:0] addr_pc_s;
    logic [31:0] byte_off_s;
    logic        unused_off_bits_s;

    assign blocked_s = valid_q & bus.Stall;
    assign aligned_s = (bus.PC[1:0] == 2'b00);
    assign inrange_s = ({1'b0, bus.PC} >= {1'b0, IMEM_BASE}) && ({1'b0, bus.PC} < LIMIT);

    // WAIT keeps requesting its latched PC; IDLE requests only a fetchable PC.
    assign req_s = !Reset && !bus.Flush && !blocked_s &&
                   ((state_q == ST_WAIT) || (aligned_s && inrange_s));
    // An ack outside an active request is a memory protocol error and is ignored.
    assign ack_s = req_s && bus.ImemAck;
    assign timeout_hit_s = (state_q == ST_WAIT) && !ack_s && (cnt_q == TO_LAST);

    assign addr_pc_s         = (state_q == ST_WAIT) ? req_pc_q : bus.PC;
    assign byte_off_s        = addr_pc_s - IMEM_BASE;
    assign unused_off_bits_s = ^{byte_off_s[31:ADDR_W+2], byte_off_s[1:0]};

    assign bus.ImemReq  = req_s;
    assign bus.ImemAddr = byte_off_s[ADDR_W+1:2];
    // Flush lets the redirect target load even if the output register is stalled.
    assign bus.PcHold   = Reset ||
                          (!bus.Flush && (blocked_s || (req_s && !bus.ImemAck && !timeout_hit_s)));

    assign bus.Instr      = instr_q;
    assign bus.InstrPC    = instr_pc_q;
    assign bus.InstrValid = valid_q;
    assign bus.FetchFault = fault_q;
    assign bus.FaultCode  = code_q;

    // Fetch FSM and IF/ID output register: flush > stall-hold > capture/fault/issue.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            req_pc_q   <= RESET_PC;
            cnt_q      <= 8'd0;
            instr_q    <= 32'd0;
            instr_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            code_q     <= FC_NONE;
        end else if (bus.Flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else if (blocked_s) begin
            state_q <= state_q;
        end else begin
            // Not blocked: any held instruction is consumed at this edge.
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!aligned_s || !inrange_s) begin
                        instr_q    <= 32'd0;
                        instr_pc_q <= bus.PC;
                        valid_q    <= 1'b1;
                        fault_q    <= 1'b1;
                        code_q     <= (!aligned_s) ? FC_MISAL : FC_RANGE;
                    end else if (ack_s) begin
                        instr_q    <= bus.ImemData;
                        instr_pc_q <= bus.PC;
                        valid_q    <= 1'b1;
                        fault_q    <= 1'b0;
                        code_q     <= FC_NONE;
                        cnt_q      <= 8'd0;
                    end else begin
                        req_pc_q <= bus.PC;
                        cnt_q    <= 8'd0;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ack_s) begin
                        instr_q    <= bus.ImemData;
                        instr_pc_q <= req_pc_q;
                        valid_q    <= 1'b1;
                        fault_q    <= 1'b0;
                        code_q     <= FC_NONE;
                        cnt_q      <= 8'd0;
                        state_q    <= ST_IDLE;
                    end else if (cnt_q == TO_LAST) begin
                        instr_q    <= 32'd0;
                        instr_pc_q <= req_pc_q;
                        valid_q    <= 1'b1;
                        fault_q    <= 1'b1;
                        code_q     <= FC_TMO;
                        cnt_q      <= 8'd0;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] BASE     = 32'h0000_3000;
    localparam int          AW       = 10;
    localparam int          TO       = 15;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ifetch_unit_if #(.ADDR_W(AW)) bus ();

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .IMEM_BASE(BASE),
        .ADDR_W   (AW),
        .TIMEOUT  (TO)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: outstanding request and the delivered instruction
    bit          m_wait;
    logic [31:0] m_rpc;
    int          m_cnt;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    bit          m_valid;
    bit          m_fault;
    logic [1:0]  m_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = fetchable, 1 = misaligned, 2 = outside instruction memory
    function automatic int fault_kind(input logic [31:0] pc);
        longint p;
        longint lo;
        longint hi;
        p  = longint'({32'd0, pc});
        lo = longint'({32'd0, BASE});
        hi = lo + 4 * (longint'(1) << AW);
        if (pc[1:0] != 2'b00) return 1;
        if (p < lo || p >= hi) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_wait  = 1'b0;
        m_rpc   = RESET_PC;
        m_cnt   = 0;
        m_instr = 32'd0;
        m_ipc   = RESET_PC;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_code  = 2'b00;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".Instr"},      bus.Instr,                m_instr);
        check({tag, ".InstrPC"},    bus.InstrPC,              m_ipc);
        check({tag, ".InstrValid"}, {31'd0, bus.InstrValid},  {31'd0, m_valid});
        check({tag, ".FetchFault"}, {31'd0, bus.FetchFault},  {31'd0, m_fault});
        check({tag, ".FaultCode"},  {30'd0, bus.FaultCode},   {30'd0, m_code});
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic [31:0] pc, input bit stall, input bit flush,
                         input bit want_ack, input logic [31:0] data);
        bit          blk;
        bit          req;
        bit          acke;
        bit          to_hit;
        bit          hold;
        int          kind;
        logic [31:0] apc;
        kind = fault_kind(pc);
        blk  = m_valid && stall;
        req  = !flush && !blk && (m_wait || kind == 0);
        acke = want_ack && req;
        // During a flush the memory may still answer; that ack must be dropped.
        bus.PC       = pc;
        bus.Stall    = stall;
        bus.Flush    = flush;
        bus.ImemData = data;
        bus.ImemAck  = want_ack && (req || flush);
        to_hit = m_wait && !acke && (m_cnt + 1 == TO);
        hold   = !flush && (blk || (req && !acke && !to_hit));
        #1;
        check("ImemReq", {31'd0, bus.ImemReq}, {31'd0, req});
        check("PcHold",  {31'd0, bus.PcHold},  {31'd0, hold});
        if (req) begin
            apc = m_wait ? m_rpc : pc;
            check("ImemAddr", {22'd0, bus.ImemAddr}, (apc - BASE) >> 2);
        end
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
            m_fault = 1'b0;
            m_code  = 2'b00;
            m_wait  = 1'b0;
            m_cnt   = 0;
        end else if (!blk) begin
            m_valid = 1'b0;
            if (acke) begin
                m_instr = data;
                m_ipc   = m_wait ? m_rpc : pc;
                m_valid = 1'b1;
                m_fault = 1'b0;
                m_code  = 2'b00;
                m_wait  = 1'b0;
                m_cnt   = 0;
            end else if (m_wait) begin
                m_cnt++;
                if (m_cnt == TO) begin
                    m_instr = 32'd0;
                    m_ipc   = m_rpc;
                    m_valid = 1'b1;
                    m_fault = 1'b1;
                    m_code  = 2'b11;
                    m_wait  = 1'b0;
                    m_cnt   = 0;
                end
            end else if (kind != 0) begin
                m_instr = 32'd0;
                m_ipc   = pc;
                m_valid = 1'b1;
                m_fault = 1'b1;
                m_code  = 2'(kind);
            end else begin
                m_wait = 1'b1;
                m_rpc  = pc;
                m_cnt  = 0;
            end
        end
        #1;
        check_regs("cyc");
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_pc();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return BASE + 32'($urandom_range(0, 4095)) * 32'd4 + 32'($urandom_range(1, 3));
        if (r == 1) return BASE - 32'd4 * 32'($urandom_range(1, 8));
        if (r == 2) return BASE + 32'd4096 + 32'd4 * 32'($urandom_range(0, 8));
        return BASE + 32'd4 * 32'($urandom_range(0, 1023));
    endfunction

    initial begin
        rst          = 1'b1;
        bus.PC       = RESET_PC;
        bus.Stall    = 1'b0;
        bus.Flush    = 1'b0;
        bus.ImemAck  = 1'b0;
        bus.ImemData = 32'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst.ImemReq", {31'd0, bus.ImemReq}, 32'd0);
        check("rst.PcHold",  {31'd0, bus.PcHold},  32'd1);
        check_regs("rst");
        rst = 1'b0;

        // Zero-wait fetch
        cycle(32'h0000_3000, 1'b0, 1'b0, 1'b1, 32'h2408_0005);
        check("zw.Instr",   bus.Instr,   32'h2408_0005);
        check("zw.InstrPC", bus.InstrPC, 32'h0000_3000);

        // Three wait cycles, then ack
        for (int i = 0; i < 3; i++) cycle(32'h0000_3004, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(32'h0000_3004, 1'b0, 1'b0, 1'b1, 32'h0000_000C);
        check("ws.InstrPC", bus.InstrPC, 32'h0000_3004);

        // Stall freezes the output register, release issues immediately
        cycle(32'h0000_3008, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        cycle(32'h0000_3008, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        check("stall.Instr", bus.Instr, 32'h0000_000C);
        cycle(32'h0000_3008, 1'b0, 1'b0, 1'b1, 32'h1111_2222);

        // Address faults
        cycle(32'h0000_3002, 1'b0, 1'b0, 1'b1, 32'h5555_5555);
        check("misal.code", {30'd0, bus.FaultCode}, 32'd1);
        cycle(32'h0000_2FFC, 1'b0, 1'b0, 1'b1, 32'h5555_5555);
        cycle(BASE + 32'd4096, 1'b0, 1'b0, 1'b1, 32'h5555_5555);
        check("range.code", {30'd0, bus.FaultCode}, 32'd2);

        // Timeout: one issue edge, then TO unacknowledged WAIT edges
        for (int i = 0; i < TO + 1; i++) cycle(32'h0000_300C, 1'b0, 1'b0, 1'b0, 32'd0);
        check("tmo.code",    {30'd0, bus.FaultCode}, 32'd3);
        check("tmo.InstrPC", bus.InstrPC, 32'h0000_300C);

        // Flush coinciding with ack in WAIT
        cycle(32'h0000_3010, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(32'h0000_3010, 1'b0, 1'b1, 1'b1, 32'h7777_7777);
        check("flush.valid", {31'd0, bus.InstrValid}, 32'd0);

        // Asynchronous reset in the middle of WAIT
        cycle(32'h0000_3014, 1'b0, 1'b0, 1'b0, 32'd0);
        cycle(32'h0000_3014, 1'b0, 1'b0, 1'b0, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst.ImemReq", {31'd0, bus.ImemReq}, 32'd0);
        check("arst.PcHold",  {31'd0, bus.PcHold},  32'd1);
        check_regs("arst");
        @(negedge clk);
        rst = 1'b0;

        // Random traffic: first ack-heavy, then ack-starved to force timeouts
        for (int i = 0; i < 600; i++) begin
            int ack_pct;
            ack_pct = (i < 350) ? 70 : 4;
            cycle(rand_pc(),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 4),
                  ($urandom_range(0, 99) < ack_pct),
                  $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
